// File: rtl/gru_pkg.sv
// rtl/gru_pkg.sv - Shared types and default constants for the GRU sequence controller
package gru_pkg;

  localparam int DEF_DATA_WIDTH  = 8;
  localparam int DEF_FRACT_WIDTH = 5;
  localparam int DEF_LEN_W       = 8;
  localparam int DEF_CELL_LAT    = 2;
  localparam int DEF_H_INIT      = 0;
  localparam int TIMER_W         = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_X  = 2'd1,
    COMPUTE = 2'd2,
    EMIT    = 2'd3
  } gru_state_e;

endpackage

// File: rtl/gru_lat_timer.sv
// rtl/gru_lat_timer.sv - Loadable count-down latency timer with zero flag
module gru_lat_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/gru_seq_ctrl.sv
// rtl/gru_seq_ctrl.sv - Sequences an external GRU cell over seq_len timesteps
// Optional abort input/aborted output enabled by macro GRU_SEQ_ABORT_EN.
module gru_seq_ctrl
  import gru_pkg::*;
#(
  parameter int                             DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int                             FRACT_WIDTH = DEF_FRACT_WIDTH,
  parameter int                             LEN_W       = DEF_LEN_W,
  parameter int                             CELL_LAT    = DEF_CELL_LAT,
  parameter logic signed [DATA_WIDTH-1:0]   H_INIT      = DATA_WIDTH'(DEF_H_INIT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LEN_W-1:0]      seq_len,
  input  logic                  x_valid,
  output logic                  x_ready,
  input  logic [DATA_WIDTH-1:0] x_data,
  output logic [DATA_WIDTH-1:0] cell_x,
  output logic [DATA_WIDTH-1:0] cell_h_in,
  input  logic [DATA_WIDTH-1:0] cell_h_out,
  output logic                  y_valid,
  input  logic                  y_ready,
  output logic [DATA_WIDTH-1:0] y_data,
  output logic                  y_last,
  output logic                  busy,
  output logic                  done
`ifdef GRU_SEQ_ABORT_EN
  ,
  input  logic                  abort,
  output logic                  aborted
`endif
);

  // H_INIT is pre-encoded with FRACT_WIDTH fraction bits; reject encodings with no integer bit.
  if (CELL_LAT < 1 || CELL_LAT > 15 || FRACT_WIDTH >= DATA_WIDTH) begin : g_param_check
    $error("gru_seq_ctrl: CELL_LAT must be 1..15 and FRACT_WIDTH < DATA_WIDTH");
  end

  gru_state_e            state, state_nxt;
  logic [LEN_W-1:0]      len_reg;
  logic [LEN_W-1:0]      step;
  logic [DATA_WIDTH-1:0] h_reg;
  logic                  tmr_zero;
  logic                  is_last;
  logic                  start_acc, zero_len, x_acc, capture, y_xfer, abort_now;

  assign is_last = (step == len_reg - 1'b1);

  gru_lat_timer #(
    .W (TIMER_W)
  ) u_lat_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (x_acc),
    .load_val (TIMER_W'(CELL_LAT)),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    start_acc = 1'b0;
    zero_len  = 1'b0;
    x_acc     = 1'b0;
    capture   = 1'b0;
    y_xfer    = 1'b0;
    abort_now = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (seq_len != '0) begin
            start_acc = 1'b1;
            state_nxt = WAIT_X;
          end else begin
            zero_len = 1'b1;
          end
        end
      end
      WAIT_X: begin
        if (x_valid) begin
          x_acc     = 1'b1;
          state_nxt = COMPUTE;
        end
      end
      COMPUTE: begin
        if (tmr_zero) begin
          capture   = 1'b1;
          state_nxt = EMIT;
        end
      end
      EMIT: begin
        if (y_ready) begin
          y_xfer    = 1'b1;
          state_nxt = is_last ? IDLE : WAIT_X;
        end
      end
      default: state_nxt = IDLE;
    endcase
`ifdef GRU_SEQ_ABORT_EN
    // Abort wins over any handshake landing on the same edge.
    if (abort && state != IDLE) begin
      abort_now = 1'b1;
      x_acc     = 1'b0;
      capture   = 1'b0;
      y_xfer    = 1'b0;
      state_nxt = IDLE;
    end
`endif
  end

  assign x_ready = (state == WAIT_X);
  assign y_valid = (state == EMIT);
  assign y_last  = y_valid & is_last;
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_reg   <= '0;
      step      <= '0;
      h_reg     <= H_INIT;
      cell_x    <= '0;
      cell_h_in <= '0;
      y_data    <= '0;
      done      <= 1'b0;
    end else begin
      done <= zero_len | (y_xfer & is_last);
      if (start_acc) begin
        len_reg <= seq_len;
        step    <= '0;
        h_reg   <= H_INIT;
      end
      if (x_acc) begin
        cell_x    <= x_data;
        cell_h_in <= h_reg;
      end
      // Feedback comes from this captured copy, never from the live cell output.
      if (capture) begin
        h_reg  <= cell_h_out;
        y_data <= cell_h_out;
      end
      if (y_xfer) begin
        step <= step + 1'b1;
      end
      if (abort_now) begin
        h_reg <= H_INIT;
      end
    end
  end

`ifdef GRU_SEQ_ABORT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aborted <= 1'b0;
    end else begin
      aborted <= abort_now;
    end
  end
`endif

endmodule
